// File: rtl/atmega_tim_prescaler_pkg.sv
// atmega_tim_prescaler_pkg: shared timer constants (GTCCR bit layout)
package atmega_tim_prescaler_pkg;
  localparam int PSRSYNC_BIT = 0;
  localparam int PSRASY_BIT = 1;
  localparam int TSM_BIT = 7;
  localparam logic [7:0] GTCCR_MASK = 8'h83;
endpackage

// File: rtl/atmega_tim_prescaler.sv
// atmega_tim_prescaler: 10-bit timer prescaler with GTCCR sync/async reset and TSM hold
module atmega_tim_prescaler
  import atmega_tim_prescaler_pkg::*;
#(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int GTCCR_ADDR = 'h43
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  output logic                         clk8,
  output logic                         clk64,
  output logic                         clk256,
  output logic                         clk1024,
  output logic                         tim_halt,
  output logic                         psrasy_pulse
);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] ADDR = BUS_ADDR_DATA_LEN'(GTCCR_ADDR);
  logic [9:0] pres_cnt;
  logic [7:0] gtccr;
  logic       sel;
  logic       psrsync;
  logic       tsm;
  assign sel = addr_dat == ADDR;
  assign psrsync = gtccr[PSRSYNC_BIT];
  assign tsm = gtccr[TSM_BIT];
  // free-running prescaler; a pending sync reset beats halt and increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) pres_cnt <= '0;
    else if (psrsync) pres_cnt <= '0;
    else if (!halt) pres_cnt <= pres_cnt + 10'd1;
  // GTCCR: bus write wins; otherwise reset requests self-clear unless TSM holds them
  always_ff @(posedge clk or negedge rst)
    if (!rst) gtccr <= '0;
    else if (wr_dat && sel) gtccr <= bus_dat_in & GTCCR_MASK;
    else if (!tsm) begin
      gtccr[PSRSYNC_BIT] <= 1'b0;
      gtccr[PSRASY_BIT] <= 1'b0;
    end
  assign clk8 = pres_cnt[2];
  assign clk64 = pres_cnt[5];
  assign clk256 = pres_cnt[7];
  assign clk1024 = pres_cnt[9];
  assign tim_halt = tsm & psrsync;
  assign psrasy_pulse = gtccr[PSRASY_BIT];
  assign bus_dat_out = (rd_dat && sel) ? gtccr : 8'h00;
endmodule
